mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU in the pipelined processor.
- Computes a DW x DW product with one shared half-width signed multiplier (a Signed_mult instance, WL = DW/2+1) over four partial-product cycles.
- Writes the 2*DW result to the HI/LO registers.
- Drives busy so the hazard unit can stall readers of HI/LO.

Parameters:
- DW, 32, operand width; must be even. H = DW/2 is the internal half width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only when idle or when done=1
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; latched with start
- op_a  input  DW  multiplicand; latched with start
- op_b  input  DW  multiplier; latched with start
- flush  input  1  synchronous cancel of the operation in flight
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when hi/lo have just been updated
- hi  output  DW  upper half of the product (HI register)
- lo  output  DW  lower half of the product (LO register)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, hi, lo, accumulator and operand registers all 0.
- States:
  - IDLE: start=1 latches op_a, op_b and is_signed. Next state ABS; busy=1.
  - ABS: if is_signed, replace each operand by its magnitude and record neg = sign_a XOR sign_b. Otherwise neg=0. Clear the 2*DW accumulator. Next state M0.
  - Magnitudes are unsigned DW-bit values; -2^(DW-1) becomes 2^(DW-1), with no overflow.
  - Split magnitudes into aH:aL and bH:bL, each H bits.
  - Each Mk cycle drives the shared multiplier with zero-extended (H+1)-bit halves. The low 2H bits of its output are the unsigned partial product.
  - M0: acc += aL*bL.
  - M1: acc += (aL*bH) << H.
  - M2: acc += (aH*bL) << H.
  - M3: acc += (aH*bH) << 2H.
  - Accumulation is modulo 2^(2*DW). Next state after M3 is SIGN.
  - SIGN: if neg, result = two's-complement negate of acc (2*DW bits); otherwise result = acc. At the edge, {hi,lo} <= result, done <= 1, busy <= 0, next state IDLE.
- Latency: start sampled at edge N gives hi/lo valid and done=1 after edge N+6. busy is high after edges N..N+5.
- done is high for exactly one cycle, then returns to 0.
- Back-to-back: start=1 in the done cycle is accepted; busy stays 0 for that cycle and rises after the next edge.
- start while busy=1 is ignored; no queueing.
- flush=1 in any non-IDLE state: next state IDLE, busy=0, no done pulse, hi/lo unchanged.
- flush has priority over start in the same cycle.
- hi/lo change only in the SIGN transition; they hold their values otherwise.
- is_signed=0: no magnitude or negation step; ABS still costs one cycle, so latency is fixed.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: if op_a==0 or op_b==0 when start is accepted, the next edge writes hi=0 and lo=0, pulses done, and returns to IDLE. busy is never asserted, and latency is 1 cycle.
- Undefined: zero operands take the full 6-cycle path and produce 0.

Test Plan:
- Signed: is_signed=1, op_a=0xFFFFFFFD (-3), op_b=7 -> 6 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned: is_signed=0, op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed corners:
  - 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
  - 0x80000000*0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- Flush mid-operation: start 5*5, flush in M2 -> no done, busy drops after that edge, hi/lo keep prior values. Restart 6*7 -> lo=42.
- Back-to-back: second start (2*3) asserted in the done cycle of the first (4*4) -> first result lo=16, second lo=6 exactly 6 cycles later; a start asserted while busy has no effect.
- Reset: assert rst_n low mid-M1 -> busy, done, hi, lo go to 0 immediately (no clock edge needed). With MULT_ZERO_SKIP_EN, 0*0x1234 -> done on the next edge, hi=lo=0, busy never high.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MULT/MULTU sequencer: one shared half-width signed multiplier, four partial products into HI/LO.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand completes in one cycle without raising busy.

module Signed_mult #(
    parameter int WL = 17
) (
    input  logic signed [WL-1:0]   a,
    input  logic signed [WL-1:0]   b,
    output logic signed [2*WL-1:0] p
);
    assign p = a * b;
endmodule

module mult_seq_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_signed,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    localparam int H  = DW / 2;
    localparam int WL = H + 1;
    localparam int AW = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_SIGN
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            sgn_q, sgn_d;
    logic            neg_q, neg_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic signed [WL-1:0]   mul_a, mul_b;
    logic signed [2*WL-1:0] prod;
    logic [AW-1:0]          pp_ext;
    logic [AW-1:0]          result;
    logic                   zero_skip;

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (op_a == '0) || (op_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    Signed_mult #(.WL(WL)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Halves are zero-extended, so the product is never negative and its top bits are always 0.
    assign pp_ext = {{(AW - 2*WL){1'b0}}, $unsigned(prod)};
    assign result = neg_q ? -acc_q : acc_q;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_M0: begin
                mul_a = {1'b0, a_q[H-1:0]};
                mul_b = {1'b0, b_q[H-1:0]};
            end
            S_M1: begin
                mul_a = {1'b0, a_q[H-1:0]};
                mul_b = {1'b0, b_q[DW-1:H]};
            end
            S_M2: begin
                mul_a = {1'b0, a_q[DW-1:H]};
                mul_b = {1'b0, b_q[H-1:0]};
            end
            S_M3: begin
                mul_a = {1'b0, a_q[DW-1:H]};
                mul_b = {1'b0, b_q[DW-1:H]};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    sgn_d = is_signed;
                    if (zero_skip) begin
                        hi_d   = '0;
                        lo_d   = '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ABS;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_ABS: begin
                // Magnitude of the most negative value wraps to 2^(DW-1), which is correct unsigned.
                if (sgn_q) begin
                    if (a_q[DW-1]) a_d = -a_q;
                    if (b_q[DW-1]) b_d = -b_q;
                    neg_d = a_q[DW-1] ^ b_q[DW-1];
                end else begin
                    neg_d = 1'b0;
                end
                acc_d   = '0;
                state_d = S_M0;
            end
            S_M0: begin
                acc_d   = acc_q + pp_ext;
                state_d = S_M1;
            end
            S_M1: begin
                acc_d   = acc_q + (pp_ext << H);
                state_d = S_M2;
            end
            S_M2: begin
                acc_d   = acc_q + (pp_ext << H);
                state_d = S_M3;
            end
            S_M3: begin
                acc_d   = acc_q + (pp_ext << (2 * H));
                state_d = S_SIGN;
            end
            S_SIGN: begin
                hi_d    = result[AW-1:DW];
                lo_d    = result[DW-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A flush abandons the operation without touching HI/LO.
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
